seq_mag_comparator: RTL

- Parametrised, iterative magnitude comparator: successor to the fixed 4-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock cycle.
- Supports unsigned and two's-complement signed modes; exits early at the first differing digit.
- Used by arithmetic/sorting datapaths that trade latency for area on wide operands, with a start/done handshake.

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/digit_comparator.sv | 19 +
 rtl/seq_mag_comparator.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the iterative magnitude comparator.
package cmp_pkg;

    typedef enum logic {
        CMP_IDLE,
        CMP_COMPARE
    } cmp_state_t;

    // Number of DIGIT-wide slices in a WIDTH-bit operand.
    function automatic int unsigned num_digits(input int unsigned width,
                                               input int unsigned digit);
        return width / digit;
    endfunction

    // Digit counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_comparator.sv
// Combinational unsigned comparator for one DIGIT-bit slice.
module digit_comparator #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    // Single-slice magnitude relation.
    always_comb begin
        gt = (x > y);
        eq = (x == y);
        lt = (x < y);
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// Iterative MSB-first magnitude comparator, DIGIT bits per cycle, with
// start/done handshake and optional two's-complement mode.
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             equal,
    output logic             less
);

    localparam int unsigned NUM_DIGITS = num_digits(WIDTH, DIGIT);
    localparam int unsigned CNT_W      = cnt_width(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic dig_gt, dig_eq, dig_lt;

    digit_comparator #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .x  (a_sh_q[WIDTH-1 -: DIGIT]),
        .y  (b_sh_q[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .eq (dig_eq),
        .lt (dig_lt)
    );

    // Next-state, operand shifting and result update.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;

        unique case (state_q)
            CMP_IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's-complement onto
                    // offset-binary, so the unsigned digit compare holds.
                    a_sh_d              = a;
                    b_sh_d              = b;
                    a_sh_d[WIDTH-1]     = a[WIDTH-1] ^ is_signed;
                    b_sh_d[WIDTH-1]     = b[WIDTH-1] ^ is_signed;
                    cnt_d               = '0;
                    gt_d                = 1'b0;
                    eq_d                = 1'b0;
                    lt_d                = 1'b0;
                    state_d             = CMP_COMPARE;
                end
            end
            CMP_COMPARE: begin
                if (!dig_eq) begin
                    gt_d    = dig_gt;
                    lt_d    = dig_lt;
                    eq_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = CMP_IDLE;
                end else if (cnt_q == LAST_DIGIT) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = CMP_IDLE;
                end else begin
                    a_sh_d = a_sh_q << DIGIT;
                    b_sh_d = b_sh_q << DIGIT;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = CMP_IDLE;
        endcase
    end

    // State, operand and result registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CMP_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    // busy is exactly the COMPARE state, so it drops on the decision edge.
    always_comb begin
        busy    = (state_q == CMP_COMPARE);
        done    = done_q;
        greater = gt_q;
        equal   = eq_q;
        less    = lt_q;
    end

endmodule
